// File: rtl/irq_ctrl.sv
// Interrupt controller: masks and prioritises level-held sources, raises one
// request to the pipeline, acks the winner on trap entry, blocks nesting until eret.
module irq_ctrl #(
    parameter int                N_SRC    = 4,
    parameter logic [N_SRC-1:0]  MASK_RST = '1,
    localparam int               CW       = $clog2(N_SRC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    output logic [N_SRC-1:0]  irq_ack,
    input  logic              int_en,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_wdata,
    output logic [N_SRC-1:0]  mask,
    output logic [N_SRC-1:0]  pending,
    output logic              int_req,
    output logic [CW-1:0]     int_cause,
    input  logic              int_taken,
    input  logic              eret,
    output logic              in_service,
    output logic [1:0]        dbg_state
);

    // Handshake: int_req holds with a frozen int_cause until int_taken (ack
    // follows for one cycle) or until the request is withdrawn; in_service
    // then holds until eret.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  ack_q, ack_d;
    logic [CW-1:0]     cause_q, cause_d;
    logic [N_SRC-1:0]  masked;
    logic [CW-1:0]     winner;
    logic              any_masked;
    logic              cause_live;

    assign masked     = irq_in & mask_q;
    assign any_masked = |masked;

    // Lowest set index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) winner = CW'(i);
        end
    end

    always_comb begin
        cause_live = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (CW'(i) == cause_q) cause_live = masked[i];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (int_en && any_masked) state_d = REQ;
            end
            REQ: begin
                if (int_taken)                   state_d = SERVICE;
                else if (!int_en || !cause_live) state_d = IDLE;
            end
            SERVICE: begin
                if (eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        mask_d    = mask_we ? mask_wdata : mask_q;
        pending_d = masked;
        cause_d   = cause_q;
        if (state_q == IDLE && state_d == REQ) cause_d = winner;
        ack_d = '0;
        if (state_q == REQ && int_taken) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (CW'(i) == cause_q) ack_d[i] = 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= MASK_RST;
            pending_q <= '0;
            ack_q     <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            cause_q   <= cause_d;
        end
    end

    // Output logic
    always_comb begin
        int_req    = (state_q == REQ);
        in_service = (state_q == SERVICE);
        int_cause  = cause_q;
        irq_ack    = ack_q;
        mask       = mask_q;
        pending    = pending_q;
        dbg_state  = state_q;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the pipeline CPU, on the receiving end of the peripheral interrupt handshake. It samples level-held interrupt lines from board sources such as the timer, masks and prioritises them, and presents a single request with cause index to the pipeline's trap logic. Once the pipeline takes the trap, it returns a one-cycle acknowledge pulse to the winning source. It then blocks further requests until the handler executes `eret`, so interrupts never nest.

## Interface
- `N_SRC`, default 4: number of interrupt sources, 2..16. Source 0 has the highest priority.
- `MASK_RST`, default all ones (`N_SRC` bits): reset value of the mask register.
- `CW`, derived as clog2(`N_SRC`): width of the cause index. It is not overridable.

- `clk`, input, 1: system clock. Single clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `irq_in`, input, `N_SRC`: interrupt levels. Each source holds its line high until it is acked.
- `irq_ack`, output, `N_SRC`: one-hot acknowledge pulse to the source being serviced.
- `int_en`, input, 1: global interrupt enable from CPU status.
- `mask_we`, input, 1: mask register write strobe.
- `mask_wdata`, input, `N_SRC`: new mask value. Bit = 1 enables that source.
- `mask`, output, `N_SRC`: current mask register.
- `pending`, output, `N_SRC`: registered `irq_in & mask`.
- `int_req`, output, 1: interrupt request to the pipeline.
- `int_cause`, output, `CW`: index of the requesting source. Valid while `int_req` or `in_service` is high.
- `int_taken`, input, 1: pipeline commits the trap this cycle.
- `eret`, input, 1: handler return, committed this cycle.
- `in_service`, output, 1: a handler is currently running.

## Operation
- Reset values (all take effect at the first edge with `reset` = 1):
  - `mask` = `MASK_RST`.
  - `pending`, `irq_ack`, `int_req`, `in_service` = 0.
  - `int_cause` = 0.
  - State = IDLE.
  - A reset in the middle of REQ or SERVICE aborts it with no ack issued.
- `pending` register: loads `irq_in & mask` on every edge.
- Mask writes:
  - A write with `mask_we` = 1 updates `mask` at the edge and is legal in any state.
  - The new mask is used by arbitration from the following cycle.
- Arbitration: the winner is the lowest set index of `irq_in & mask`, evaluated combinationally.
- State IDLE:
  - If `int_en` = 1 and the masked vector is nonzero: go to REQ, latch the winner into `int_cause`, set `int_req` = 1.
  - `eret` and `int_taken` are ignored.
- State REQ (`int_req` = 1):
  - `int_cause` is frozen. No re-arbitration happens, even if a higher-priority source rises.
  - If `int_taken` = 1: go to SERVICE, set `int_req` = 0, set `in_service` = 1, drive `irq_ack[int_cause]` = 1 for exactly the next cycle.
  - Else, if `int_en` = 0 or `irq_in[int_cause] & mask[int_cause]` = 0: withdraw to IDLE, set `int_req` = 0, issue no ack.
  - `int_taken` has priority over withdrawal when both conditions hold in the same cycle.
  - `eret` is ignored.
- State SERVICE (`in_service` = 1):
  - No new requests are raised.
  - On `eret` = 1: go to IDLE, clear `in_service`.
  - `eret` in the very first SERVICE cycle (the ack cycle) is legal. The source has dropped its line by the time IDLE re-arbitrates.
  - `int_taken` is ignored.
- Only one bit of `irq_ack` is ever high, and it is never high outside the first SERVICE cycle.

## Timing
- `irq_in` is high before edge k, with `int_en` = 1 and the source unmasked. Then `int_req` = 1 and `int_cause` are valid from cycle k+1. Request latency is 1 cycle.
- `int_taken` is sampled at edge t. Then `irq_ack` is high during cycle t+1 only, `in_service` is high from cycle t+1, and `int_req` is low from cycle t+1.
- `eret` is sampled at edge e. Then `in_service` is low from cycle e+1, and a new `int_req` can appear at cycle e+2 at the earliest.
- Back-to-back sources: with source 1 still held after source 0 is serviced, source 1 is requested at the earliest 2 cycles after `eret`.
- A mask write at edge m affects arbitration in cycle m+1. `pending` reflects it at cycle m+2.

## Test plan
- Single source:
  - Stimulus: `irq_in` = 4'b0001 at cycle 0, `int_taken` at cycle 3, source drops the line on ack, `eret` at cycle 8.
  - Required: `int_req` high in cycles 1..3, `int_cause` = 0, `irq_ack` = 4'b0001 in cycle 4 only, `in_service` high in cycles 4..8, IDLE at cycle 9, no second request.
- Priority and freeze:
  - Stimulus: `irq_in` = 4'b1100, then bit 0 rises while in REQ.
  - Required: `int_cause` stays 2. After `eret`, the next request has cause 0, then cause 3 after that one is serviced.
- Withdrawal:
  - Stimulus: while in REQ with cause 1, write `mask` = 4'b1101.
  - Required: `int_req` falls the cycle after the write, no `irq_ack` is issued, state returns to IDLE.
- Gating:
  - Stimulus: `int_en` = 0 with `irq_in` = 4'b0010 held for 10 cycles, then `int_en` = 1.
  - Required: no request while disabled, `pending` = 4'b0010, `int_req` high 1 cycle after enable.
- Simultaneous events:
  - Stimulus: `int_taken` and an `int_en` drop in the same REQ cycle.
  - Required: goes to SERVICE with ack issued. Also: `eret` during the ack cycle returns to IDLE with no spurious re-request.
- Reset mid-operation:
  - Stimulus: assert `reset` in SERVICE.
  - Required: all outputs return to reset values at the next edge, `mask` = `MASK_RST`, no ack is emitted.
